// File: rtl/avalon_2to1_arbiter.sv
// Two-host Avalon-MM arbiter sharing one downstream port between the
// instruction bus (host 0) and the data bus (host 1). Round-robin per
// transaction, grant locked across waitrequest stalls, and an in-order tag
// FIFO steers pipelined read responses back to the issuing host.
module avalon_2to1_arbiter #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              h0_read,
    input  logic              h0_write,
    input  logic [AW-1:0]     h0_address,
    input  logic [DW-1:0]     h0_writedata,
    input  logic [DW/8-1:0]   h0_byteenable,
    output logic              h0_waitrequest,
    output logic [DW-1:0]     h0_readdata,
    output logic              h0_readdatavalid,

    input  logic              h1_read,
    input  logic              h1_write,
    input  logic [AW-1:0]     h1_address,
    input  logic [DW-1:0]     h1_writedata,
    input  logic [DW/8-1:0]   h1_byteenable,
    output logic              h1_waitrequest,
    output logic [DW-1:0]     h1_readdata,
    output logic              h1_readdatavalid,

    output logic              m_read,
    output logic              m_write,
    output logic [AW-1:0]     m_address,
    output logic [DW-1:0]     m_writedata,
    output logic [DW/8-1:0]   m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DW-1:0]     m_readdata,
    input  logic              m_readdatavalid
);

    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    // Arbitration state
    logic                       r_lock;
    logic                       r_owner;
    logic                       r_rr_next;

    // Tag FIFO: one bit per entry naming the host that issued the read
    logic [MAX_OUTSTANDING-1:0] r_tag;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_count;

    logic                       w_req0;
    logic                       w_req1;
    logic                       w_sel;
    logic                       w_sel_read;
    logic                       w_sel_write;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_block;
    logic                       w_wait_sel;
    logic                       w_issue;
    logic                       w_accept;
    logic                       w_head;
    logic [CW-1:0]              w_count_net;

    // Grant selection, command mux, stall and response routing
    always_comb begin
        w_req0      = h0_read | h0_write;
        w_req1      = h1_read | h1_write;

        w_sel       = r_rr_next;
        if (r_lock)
            w_sel = r_owner;
        else if (r_rr_next ? w_req1 : w_req0)
            w_sel = r_rr_next;
        else if (r_rr_next ? w_req0 : w_req1)
            w_sel = ~r_rr_next;

        // A host raising both read and write is treated as a read
        w_sel_read  = w_sel ? h1_read : h0_read;
        w_sel_write = w_sel ? (h1_write & ~h1_read) : (h0_write & ~h0_read);

        // A response with an empty FIFO is ignored so the count cannot wrap
        w_pop       = m_readdatavalid & (r_count != '0);
        w_count_net = r_count - CW'(w_pop);
        w_block     = w_sel_read & (w_count_net == CW'(MAX_OUTSTANDING));

        m_read       = w_sel_read & ~w_block & ~rst;
        m_write      = w_sel_write & ~rst;
        m_address    = w_sel ? h1_address    : h0_address;
        m_writedata  = w_sel ? h1_writedata  : h0_writedata;
        m_byteenable = w_sel ? h1_byteenable : h0_byteenable;

        w_wait_sel     = m_waitrequest | w_block;
        h0_waitrequest = rst | w_sel  | w_wait_sel;
        h1_waitrequest = rst | ~w_sel | w_wait_sel;

        w_head           = r_tag[r_rd_ptr];
        h0_readdatavalid = w_pop & ~w_head & ~rst;
        h1_readdatavalid = w_pop &  w_head & ~rst;
        h0_readdata      = m_readdata;
        h1_readdata      = m_readdata;

        w_issue  = m_read | m_write;
        w_accept = w_issue & ~m_waitrequest;
        w_push   = w_accept & m_read;
    end

    // Grant lock, round-robin pointer and tag FIFO bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_owner   <= 1'b0;
            r_rr_next <= 1'b0;
            r_tag     <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_accept) begin
                r_lock    <= 1'b0;
                r_rr_next <= ~w_sel;
            end else if (w_issue) begin
                r_lock  <= 1'b1;
                r_owner <= w_sel;
            end
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_sel;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Downstream must never return a read that was not issued
    a_no_orphan_response: assert property (@(posedge clk) disable iff (rst)
        !(m_readdatavalid && (r_count == '0)));

endmodule

// File: tb/tb_avalon_2to1_arbiter.sv
// Bench for avalon_2to1_arbiter: directed scenarios plus a randomized run
// against a queue-based transaction model of the arbitration rules.
module tb_avalon_2to1_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = DW / 8;
    localparam int          MAXO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          h0_read, h0_write, h1_read, h1_write;
    logic [AW-1:0] h0_address, h1_address;
    logic [DW-1:0] h0_writedata, h1_writedata;
    logic [BW-1:0] h0_byteenable, h1_byteenable;
    logic          h0_waitrequest, h1_waitrequest;
    logic [DW-1:0] h0_readdata, h1_readdata;
    logic          h0_readdatavalid, h1_readdatavalid;
    logic          m_read, m_write;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic [BW-1:0] m_byteenable;
    logic          m_waitrequest;
    logic [DW-1:0] m_readdata;
    logic          m_readdatavalid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avalon_2to1_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk              (clk),
        .rst              (rst),
        .h0_read          (h0_read),
        .h0_write         (h0_write),
        .h0_address       (h0_address),
        .h0_writedata     (h0_writedata),
        .h0_byteenable    (h0_byteenable),
        .h0_waitrequest   (h0_waitrequest),
        .h0_readdata      (h0_readdata),
        .h0_readdatavalid (h0_readdatavalid),
        .h1_read          (h1_read),
        .h1_write         (h1_write),
        .h1_address       (h1_address),
        .h1_writedata     (h1_writedata),
        .h1_byteenable    (h1_byteenable),
        .h1_waitrequest   (h1_waitrequest),
        .h1_readdata      (h1_readdata),
        .h1_readdatavalid (h1_readdatavalid),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_address        (m_address),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid)
    );

    task automatic idle_inputs();
        h0_read = 1'b0; h0_write = 1'b0; h0_address = '0; h0_writedata = '0; h0_byteenable = '0;
        h1_read = 1'b0; h1_write = 1'b0; h1_address = '0; h1_writedata = '0; h1_byteenable = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    endtask

    // Leaves the bench just after a rising edge with rst released
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        h0_read = 1'b1; h1_write = 1'b1; m_readdatavalid = 1'b1;
        @(negedge clk);
        n_tests++; if (h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_h0_wait got %b exp 1", h0_waitrequest); end
        n_tests++; if (h1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_h1_wait got %b exp 1", h1_waitrequest); end
        n_tests++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL reset_m_read got %b exp 0", m_read); end
        n_tests++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL reset_m_write got %b exp 0", m_write); end
        n_tests++; if ({h0_readdatavalid, h1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rdv got %b exp 00", {h0_readdatavalid, h1_readdatavalid}); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        h0_read = 1'b1; h0_address = 32'h100;
        @(negedge clk);
        n_tests++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL single_m_read got %b exp 1", m_read); end
        n_tests++; if (m_address !== 32'h100) begin n_fail++; $display("FAIL single_addr got %h exp 00000100", m_address); end
        n_tests++; if (h0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL single_h0_wait got %b exp 0", h0_waitrequest); end
        next_cycle();
        h0_read = 1'b0;
        next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++; if (h0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL single_h0_rdv got %b exp 1", h0_readdatavalid); end
        n_tests++; if (h0_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_h0_data got %h exp deadbeef", h0_readdata); end
        n_tests++; if (h1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL single_h1_rdv got %b exp 0", h1_readdatavalid); end
        next_cycle();
        m_readdatavalid = 1'b0;
    endtask

    task automatic test_alternate();
        int k0 = 0;
        int k1 = 0;
        logic [AW-1:0] exp_a;
        do_reset();
        for (int i = 0; i < MAXO; i++) begin
            h0_read = 1'b1; h0_address = 32'h1000 + AW'(k0);
            h1_read = 1'b1; h1_address = 32'h2000 + AW'(k1);
            exp_a = (i % 2 == 0) ? 32'h1000 + AW'(i / 2) : 32'h2000 + AW'(i / 2);
            @(negedge clk);
            n_tests++; if (m_address !== exp_a) begin n_fail++; $display("FAIL alt_addr[%0d] got %h exp %h", i, m_address, exp_a); end
            n_tests++; if ({h1_waitrequest, h0_waitrequest} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL alt_wait[%0d] got h1h0=%b exp %b", i, {h1_waitrequest, h0_waitrequest}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i % 2 == 0) k0++; else k1++;
            next_cycle();
        end
        h0_read = 1'b0; h1_read = 1'b0;
        for (int j = 0; j < MAXO; j++) begin
            m_readdatavalid = 1'b1; m_readdata = 32'hA0 + DW'(j);
            @(negedge clk);
            n_tests++; if ({h1_readdatavalid, h0_readdatavalid} !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL alt_route[%0d] got h1h0=%b exp %b", j, {h1_readdatavalid, h0_readdatavalid}, (j % 2 == 0) ? 2'b01 : 2'b10);
            end
            n_tests++; if (((j % 2 == 0) ? h0_readdata : h1_readdata) !== 32'hA0 + DW'(j)) begin
                n_fail++; $display("FAIL alt_data[%0d] got %h exp %h", j, (j % 2 == 0) ? h0_readdata : h1_readdata, 32'hA0 + DW'(j));
            end
            next_cycle();
        end
        m_readdatavalid = 1'b0;
    endtask

    task automatic test_write_stall();
        do_reset();
        h1_write = 1'b1; h1_address = 32'h3333_0000; h1_writedata = 32'h5555_AAAA; h1_byteenable = 4'hF;
        for (int c = 0; c < 4; c++) begin
            m_waitrequest = (c < 3);
            if (c >= 1) begin h0_read = 1'b1; h0_address = 32'h4444; end
            @(negedge clk);
            n_tests++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_fail++; $display("FAIL stall_cmd[%0d] got w=%b r=%b exp w=1 r=0", c, m_write, m_read); end
            n_tests++; if (m_address !== 32'h3333_0000) begin n_fail++; $display("FAIL stall_addr[%0d] got %h exp 33330000", c, m_address); end
            n_tests++; if (h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL stall_h0_wait[%0d] got %b exp 1", c, h0_waitrequest); end
            n_tests++; if (h1_waitrequest !== (c < 3)) begin n_fail++; $display("FAIL stall_h1_wait[%0d] got %b exp %b", c, h1_waitrequest, (c < 3)); end
            next_cycle();
        end
        h1_write = 1'b0; m_waitrequest = 1'b0;
        @(negedge clk);
        n_tests++; if (m_read !== 1'b1 || m_address !== 32'h4444) begin n_fail++; $display("FAIL stall_h0_grant got r=%b a=%h exp r=1 a=00004444", m_read, m_address); end
        n_tests++; if (h0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL stall_h0_release got %b exp 0", h0_waitrequest); end
        next_cycle();
        h0_read = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < MAXO; i++) begin
            h0_read = 1'b1; h0_address = AW'(i);
            @(negedge clk);
            n_tests++; if (m_read !== 1'b1 || h0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL fill[%0d] got r=%b wait=%b exp r=1 wait=0", i, m_read, h0_waitrequest); end
            next_cycle();
        end
        h0_address = 32'h55;
        @(negedge clk);
        n_tests++; if (m_read !== 1'b0 || h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_block got r=%b wait=%b exp r=0 wait=1", m_read, h0_waitrequest); end
        next_cycle();
        m_readdatavalid = 1'b1; m_readdata = 32'h1234;
        @(negedge clk);
        n_tests++; if (m_read !== 1'b1 || h0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL full_pop_accept got r=%b wait=%b exp r=1 wait=0", m_read, h0_waitrequest); end
        n_tests++; if (h0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL full_pop_rdv got %b exp 1", h0_readdatavalid); end
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge clk);
        n_tests++; if (m_read !== 1'b0 || h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_still_full got r=%b wait=%b exp r=0 wait=1", m_read, h0_waitrequest); end
        next_cycle();
    endtask

    // Continues from the full FIFO left by test_fifo_full
    task automatic test_write_when_full();
        h0_read = 1'b0;
        h1_write = 1'b1; h1_address = 32'h77; h1_writedata = 32'hCAFE; h1_byteenable = 4'h3;
        @(negedge clk);
        n_tests++; if (m_write !== 1'b1 || h1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL full_write got w=%b wait=%b exp w=1 wait=0", m_write, h1_waitrequest); end
        n_tests++; if (m_writedata !== 32'hCAFE || m_byteenable !== 4'h3) begin n_fail++; $display("FAIL full_write_data got %h/%h exp 0000cafe/3", m_writedata, m_byteenable); end
        next_cycle();
        h1_write = 1'b0; h0_read = 1'b1;
        @(negedge clk);
        n_tests++; if (m_read !== 1'b0 || h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_after_write got r=%b wait=%b exp r=0 wait=1", m_read, h0_waitrequest); end
        next_cycle();
        h0_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            h0_read = 1'b1; h0_address = AW'(i);
            next_cycle();
        end
        #2;
        rst = 1'b1; m_readdatavalid = 1'b1;
        #1;
        n_tests++; if ({h0_readdatavalid, h1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL midrst_rdv got %b exp 00", {h0_readdatavalid, h1_readdatavalid}); end
        n_tests++; if ({h0_waitrequest, h1_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL midrst_wait got %b exp 11", {h0_waitrequest, h1_waitrequest}); end
        n_tests++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL midrst_m_read got %b exp 0", m_read); end
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge clk);
        n_tests++; if (h0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL midrst_hold_wait got %b exp 1", h0_waitrequest); end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < MAXO; i++) begin
            h0_address = 32'h900 + AW'(i);
            @(negedge clk);
            n_tests++; if (h0_waitrequest !== 1'b0 || m_read !== 1'b1) begin n_fail++; $display("FAIL midrst_refill[%0d] got wait=%b r=%b exp wait=0 r=1", i, h0_waitrequest, m_read); end
            next_cycle();
        end
        h0_read = 1'b0;
    endtask

    task automatic test_random();
        logic          p_v[2];
        logic          p_rd[2];
        logic [AW-1:0] p_a[2];
        logic [DW-1:0] p_d[2];
        logic [BW-1:0] p_b[2];
        int            tags[$];
        logic [DW-1:0] sdata[$];
        int            lock, owner, rr, s, head;
        logic          mwr, pop, blk, e_rd, e_wr, e_w0, e_w1, e_v0, e_v1;
        do_reset();
        lock = 0; owner = 0; rr = 0;
        for (int h = 0; h < 2; h++) begin
            p_v[h] = 1'b0; p_rd[h] = 1'b0; p_a[h] = '0; p_d[h] = '0; p_b[h] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int h = 0; h < 2; h++) begin
                if (!p_v[h] && $urandom_range(0, 99) < 60) begin
                    p_v[h]  = 1'b1;
                    p_rd[h] = ($urandom_range(0, 99) < 60);
                    p_a[h]  = $urandom;
                    p_d[h]  = $urandom;
                    p_b[h]  = BW'($urandom);
                end
            end
            h0_read = p_v[0] && p_rd[0]; h0_write = p_v[0] && !p_rd[0];
            h0_address = p_a[0]; h0_writedata = p_d[0]; h0_byteenable = p_b[0];
            h1_read = p_v[1] && p_rd[1]; h1_write = p_v[1] && !p_rd[1];
            h1_address = p_a[1]; h1_writedata = p_d[1]; h1_byteenable = p_b[1];
            mwr = ($urandom_range(0, 99) < 30);
            pop = (tags.size() > 0) && ($urandom_range(0, 99) < 40);
            m_waitrequest   = mwr;
            m_readdatavalid = pop;
            m_readdata      = pop ? sdata[0] : DW'($urandom);

            if (lock != 0)      s = owner;
            else if (p_v[rr])   s = rr;
            else if (p_v[1-rr]) s = 1 - rr;
            else                s = rr;
            blk  = p_v[s] && p_rd[s] && ((tags.size() - (pop ? 1 : 0)) == MAXO);
            e_rd = p_v[s] && p_rd[s] && !blk;
            e_wr = p_v[s] && !p_rd[s];
            e_w0 = (s == 0) ? (mwr || blk) : 1'b1;
            e_w1 = (s == 1) ? (mwr || blk) : 1'b1;
            head = pop ? tags[0] : -1;
            e_v0 = (head == 0);
            e_v1 = (head == 1);

            @(negedge clk);
            n_tests++; if (m_read !== e_rd || m_write !== e_wr) begin n_fail++; $display("FAIL rnd_cmd c=%0d got r=%b w=%b exp r=%b w=%b", c, m_read, m_write, e_rd, e_wr); end
            n_tests++; if (h0_waitrequest !== e_w0 || h1_waitrequest !== e_w1) begin n_fail++; $display("FAIL rnd_wait c=%0d got h0=%b h1=%b exp h0=%b h1=%b", c, h0_waitrequest, h1_waitrequest, e_w0, e_w1); end
            n_tests++; if (h0_readdatavalid !== e_v0 || h1_readdatavalid !== e_v1) begin n_fail++; $display("FAIL rnd_rdv c=%0d got h0=%b h1=%b exp h0=%b h1=%b", c, h0_readdatavalid, h1_readdatavalid, e_v0, e_v1); end
            if (e_rd || e_wr) begin
                n_tests++; if (m_address !== p_a[s] || m_byteenable !== p_b[s]) begin n_fail++; $display("FAIL rnd_addr c=%0d got %h/%h exp %h/%h", c, m_address, m_byteenable, p_a[s], p_b[s]); end
            end
            if (e_wr) begin
                n_tests++; if (m_writedata !== p_d[s]) begin n_fail++; $display("FAIL rnd_wdata c=%0d got %h exp %h", c, m_writedata, p_d[s]); end
            end
            if (pop) begin
                n_tests++; if (((head == 0) ? h0_readdata : h1_readdata) !== sdata[0]) begin
                    n_fail++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, (head == 0) ? h0_readdata : h1_readdata, sdata[0]);
                end
            end

            if ((e_rd || e_wr) && !mwr) begin
                lock = 0;
                rr   = 1 - s;
                if (e_rd) begin
                    tags.push_back(s);
                    sdata.push_back(DW'($urandom));
                end
                p_v[s] = 1'b0;
            end else if (e_rd || e_wr) begin
                lock  = 1;
                owner = s;
            end
            if (pop) begin
                void'(tags.pop_front());
                void'(sdata.pop_front());
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_alternate();
        test_write_stall();
        test_fifo_full();
        test_write_when_full();
        test_reset_mid();
        test_random();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
